branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side companion to the execute-stage branching unit. Predicts conditional-branch direction and target at fetch with a table of 2-bit saturating counters. Holds in-flight predictions in order and compares each against the resolved decision when the execute stage reports it. On a wrong guess it raises a registered mispredict/redirect to the PC logic and pipeline flush.

## Interface
- `BHT_ENTRIES`, 16: number of 2-bit counters, power of two; `IDX_W = log2(BHT_ENTRIES)`.
- `INFL_DEPTH`, 4: maximum unresolved predicted branches, power of two.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `f_valid` input 1: fetch presents an instruction this cycle.
- `f_is_branch` input 1: predecode says the instruction is a conditional branch (opcode 1100011).
- `f_pc` input 32: PC of the fetched instruction.
- `f_imm` input 32: sign-extended B-type immediate.
- `f_ready` output 1: in-flight queue not full and no mispredict pulse this cycle.
- `pred_taken` output 1: predicted direction; combinational.
- `pred_target` output 32: `f_pc + f_imm`; combinational, modulo 2^32.
- `r_valid` input 1: execute stage resolves the oldest in-flight branch; this is the branching signal B in EX.
- `r_branch` input 1: actual decision from the branching unit.
- `r_target` input 32: actual taken target computed in EX.
- `mispredict` output 1: registered one-cycle pulse. Drives the flush of IF/ID/EX and selects `redirect_pc`.
- `redirect_pc` output 32: registered; meaningful only while `mispredict` is 1.
- `mispredict_count` output 16: saturating count of mispredicts.
- `err` output 1: sticky flag. Set when `r_valid` arrives while the queue is empty.

## Operation
- Index: `idx = f_pc[IDX_W+1:2]`. The prediction is `bht[idx][1]`.
- Push: a push occurs when `f_valid & f_is_branch & f_ready`. It writes `{pc, idx, pred_taken}` into the queue tail.
- Pop: `r_valid` pops the queue head. Resolutions always arrive in program order.
- Counter update on pop, at the head's idx:
  - `r_branch = 1`: increment, saturating at 3.
  - `r_branch = 0`: decrement, saturating at 0.
- Mispredict condition: the head's `pred_taken != r_branch`.
- Actions on the next edge after a mispredict:
  - `mispredict <= 1`.
  - `redirect_pc <= r_branch ? r_target : head.pc + 4`.
  - The whole queue is flushed, since younger entries are wrong path.
  - `mispredict_count` increments unless it is 0xFFFF.
- A correctly predicted pop leaves `mispredict` at 0 on the next edge.
- Target check: if the prediction was correct and taken but `r_target != head.pc + f_imm_at_push`, the spec still treats it as correct. Direct B-type targets cannot differ, so no target field is stored beyond the PC.
- Simultaneous push and pop on a correct prediction: both take effect. Occupancy is unchanged, and this is allowed when full.
- Simultaneous push and pop on a mispredict: the flush wins and the push is discarded.
- Pop when empty: ignored, and `err <= 1` until reset.
- Full: `f_ready = 0`. The fetch stage stalls, and pushes attempted while not ready are ignored.
- Lookup and update to the same idx in the same cycle: the lookup sees the old counter (no bypass).
- Queue occupancy counter is `log2(INFL_DEPTH)+1` bits. Head and tail pointers wrap modulo `INFL_DEPTH`.

## Timing
- Prediction has zero latency: outputs are combinational from `f_pc` and the BHT registers.
- Resolution to `mispredict` is one cycle. The pulse lasts exactly one cycle, and so does `f_ready` low in that cycle.
- Counter updates are visible to lookups in the following cycle.
- Reset values:
  - All BHT counters = 2'b01 (weakly not-taken).
  - Queue empty, pointers 0.
  - `mispredict = 0`, `redirect_pc = 0`, `mispredict_count = 0`, `err = 0`.
  - `f_ready = 1` after reset.
- Reset asserted mid-operation immediately clears all state, including a pending mispredict pulse.
- No state machine beyond the queue and the 1-cycle mispredict register.

## Structure
- Add to the shared defines header: the B-type opcode constant, the counter encodings (`SNT=0`, `WNT=1`, `WT=2`, `ST=3`), and the BHT reset value.
- Natural sub-module: `branch_inflight_fifo`, a parameterized synchronous FIFO with a `flush` input. It provides push/pop/full/empty and a head read port.
- BHT and mispredict logic live in the top module.

## Test plan
- After reset, push pc=0x100, imm=0x20 → `pred_taken=0`, `pred_target=0x120`. Then `r_valid` with `r_branch=1`, `r_target=0x120` → next cycle `mispredict=1`, `redirect_pc=0x120`, `mispredict_count=1`, and the counter becomes 2.
- Repeat the same branch taken twice more → the second lookup predicts taken with no mispredict. The counter saturates at 3, and a further taken resolution keeps it at 3.
- Push 4 branches → `f_ready=0`. The 5th push is ignored. A correct pop plus a push in the same cycle keeps occupancy at 4.
- Push pcs 0x200, 0x204, 0x208, then mispredict the first as not-taken after a predicted-taken → `redirect_pc=0x204`, the queue is empty, and a further `r_valid` sets `err`.
- Mispredict on pop with a simultaneous push → the push is dropped and occupancy is 0 after the edge.
- Assert `rst` in the cycle after a mispredicting `r_valid` → `mispredict` stays 0, all counters read WNT, and `mispredict_count=0`.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants, counter encodings and helpers for the branch predictor
//
// Contents:
//   OPC_BRANCH   : RV32 conditional-branch (B-type) opcode.
//   bht_ctr_e    : 2-bit saturating counter encodings SNT/WNT/WT/ST.
//   BHT_RST      : counter value every BHT entry takes on reset.
//   ctr_update() : saturating counter step toward the resolved direction.
package branch_predictor_pkg;

  localparam int XLEN = 32;
  localparam int MCNT_W = 16;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_ctr_e;

  localparam bht_ctr_e BHT_RST = WNT;

  function automatic bht_ctr_e ctr_update(input bht_ctr_e c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : bht_ctr_e'(c + 2'd1);
    end
    return (c == SNT) ? SNT : bht_ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch/resolve/redirect signal bundle for the branch predictor
//
// Signals:
//   fetch side  : f_valid, f_is_branch, f_pc, f_imm (to predictor);
//                 f_ready, pred_taken, pred_target (from predictor)
//   resolve side: r_valid, r_branch, r_target (to predictor)
//   redirect    : mispredict, redirect_pc, mispredict_count, err (from predictor)
// Modports: master = pipeline driving fetch/resolve, slave = predictor.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic              f_valid;
  logic              f_is_branch;
  logic [XLEN-1:0]   f_pc;
  logic [XLEN-1:0]   f_imm;
  logic              f_ready;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;

  logic              r_valid;
  logic              r_branch;
  logic [XLEN-1:0]   r_target;

  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [MCNT_W-1:0] mispredict_count;
  logic              err;

  modport master (
    output f_valid, f_is_branch, f_pc, f_imm, r_valid, r_branch, r_target,
    input  f_ready, pred_taken, pred_target, mispredict, redirect_pc,
           mispredict_count, err
  );

  modport slave (
    input  f_valid, f_is_branch, f_pc, f_imm, r_valid, r_branch, r_target,
    output f_ready, pred_taken, pred_target, mispredict, redirect_pc,
           mispredict_count, err
  );

endinterface

// File: rtl/branch_inflight_fifo.sv
// rtl/branch_inflight_fifo.sv - in-order queue of unresolved predictions with flush
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : enqueue din_i (accepted when not full, or when a pop frees a slot)
//   pop_i     : dequeue head (ignored when empty)
//   flush_i   : discard all entries; wins over push and pop
//   din_i     : entry to enqueue
//   head_o    : oldest entry (valid when !empty_o)
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
module branch_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[head_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[tail_q] <= din_i;
    end
  end

  // Pointers are PW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit BHT direction predictor with in-order resolution and redirect
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bp       : branch_predictor_if.slave
//              fetch lookup  -> pred_taken / pred_target (combinational), f_ready
//              resolution    -> BHT update, registered mispredict + redirect_pc
//              status        -> mispredict_count (saturating), err (sticky pop-when-empty)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int INFL_DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int ENT_W = XLEN + IDX_W + 1;

  bht_ctr_e bht_q [BHT_ENTRIES];

  logic [IDX_W-1:0]  f_idx;
  logic              push, pop_ok;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  push_data, head_data;
  logic [XLEN-1:0]   head_pc;
  logic [IDX_W-1:0]  head_idx;
  logic              head_pred;

  logic              misp_d, misp_q;
  logic [XLEN-1:0]   redirect_d, redirect_q;
  logic [MCNT_W-1:0] mcnt_d, mcnt_q;
  logic              err_d, err_q;
  bht_ctr_e          ctr_d;

  // Lookup reads the registered table only: an update this cycle is seen next cycle.
  assign f_idx          = bp.f_pc[IDX_W+1:2];
  assign bp.pred_taken  = bht_q[f_idx][1];
  assign bp.pred_target = bp.f_pc + bp.f_imm;

  assign pop_ok = bp.r_valid & ~fifo_empty;
  assign misp_d = pop_ok & (head_pred != bp.r_branch);

  // A correct pop frees a slot this cycle, letting a full queue take a push.
  // During the redirect pulse fetch is stalled outright.
  assign bp.f_ready = (~fifo_full | (pop_ok & ~misp_d)) & ~misp_q;
  assign push       = bp.f_valid & bp.f_is_branch & bp.f_ready;
  assign push_data  = {bp.f_pc, f_idx, bp.pred_taken};
  assign {head_pc, head_idx, head_pred} = head_data;

  // Flushing on a mispredict also drops any push from the same cycle: it is wrong path.
  branch_inflight_fifo #(
    .DEPTH (INFL_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (bp.r_valid),
    .flush_i (misp_d),
    .din_i   (push_data),
    .head_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    ctr_d      = ctr_update(bht_q[head_idx], bp.r_branch);
    redirect_d = redirect_q;
    if (misp_d) begin
      redirect_d = bp.r_branch ? bp.r_target : head_pc + 32'd4;
    end
    mcnt_d = mcnt_q;
    if (misp_d && (mcnt_q != '1)) begin
      mcnt_d = mcnt_q + 1'b1;
    end
    err_d = err_q | (bp.r_valid & fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= BHT_RST;
      end
    end else if (pop_ok) begin
      bht_q[head_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misp_q     <= 1'b0;
      redirect_q <= '0;
      mcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      misp_q     <= misp_d;
      redirect_q <= redirect_d;
      mcnt_q     <= mcnt_d;
      err_q      <= err_d;
    end
  end

  assign bp.mispredict       = misp_q;
  assign bp.redirect_pc      = redirect_q;
  assign bp.mispredict_count = mcnt_q;
  assign bp.err              = err_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor against a queue/array model
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int NB = 16;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bif();

  branch_predictor #(.BHT_ENTRIES(NB), .INFL_DEPTH(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bif)
  );

  typedef struct {
    logic [31:0] pc;
    int          idx;
    bit          pred;
  } infl_t;

  int          m_bht [NB];
  infl_t       m_q [$];
  bit          m_misp;
  logic [31:0] m_redir;
  int          m_cnt;
  bit          m_err;

  int checks;
  int errors;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NB);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_bht[idx_of(pc)] >= 2;
  endfunction

  function automatic bit m_ready();
    bit pop_corr;
    pop_corr = bif.r_valid && (m_q.size() > 0) && (m_q[0].pred == bif.r_branch);
    return !m_misp && ((m_q.size() < ND) || pop_corr);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) m_bht[i] = 1;
    m_q.delete();
    m_misp = 0; m_redir = 0; m_cnt = 0; m_err = 0;
  endfunction

  task automatic drive(input bit fv, input bit fb, input logic [31:0] pc, input logic [31:0] imm,
                       input bit rv, input bit rb, input logic [31:0] rt);
    @(negedge clk);
    bif.f_valid = fv; bif.f_is_branch = fb; bif.f_pc = pc; bif.f_imm = imm;
    bif.r_valid = rv; bif.r_branch = rb; bif.r_target = rt;
    #1;
  endtask

  // Advances the model by one clock from the currently driven inputs, then lets the DUT clock.
  task automatic tick();
    bit    rdy, flush, pred, nmisp;
    int    pidx;
    infl_t h;
    rdy = m_ready(); flush = 0; nmisp = 0;
    pred = m_pred(bif.f_pc); pidx = idx_of(bif.f_pc);
    if (bif.r_valid) begin
      if (m_q.size() == 0) begin
        m_err = 1;
      end else begin
        h = m_q.pop_front();
        if (bif.r_branch) begin
          if (m_bht[h.idx] < 3) m_bht[h.idx]++;
        end else begin
          if (m_bht[h.idx] > 0) m_bht[h.idx]--;
        end
        if (h.pred != bif.r_branch) begin
          nmisp = 1;
          m_redir = bif.r_branch ? bif.r_target : h.pc + 32'd4;
          if (m_cnt < 65535) m_cnt++;
          m_q.delete();
          flush = 1;
        end
      end
    end
    if (bif.f_valid && bif.f_is_branch && rdy && !flush)
      m_q.push_back('{pc: bif.f_pc, idx: pidx, pred: pred});
    m_misp = nmisp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 32'h100, 32'h0, 0, 0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL reset_misp got %0h exp 0", bif.mispredict); end
    checks++; if (bif.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %0h exp 0", bif.redirect_pc); end
    checks++; if (bif.mispredict_count !== 16'h0) begin errors++; $display("FAIL reset_count got %0h exp 0", bif.mispredict_count); end
    checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", bif.err); end
    checks++; if (bif.f_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", bif.f_ready); end
    checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %0h exp 0", bif.pred_taken); end
  endtask

  task automatic test_first_mispredict();
    drive(1, 1, 32'h100, 32'h20, 0, 0, 32'h0);
    checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL first_pred got %0h exp 0", bif.pred_taken); end
    checks++; if (bif.pred_target !== 32'h120) begin errors++; $display("FAIL first_target got %0h exp 120", bif.pred_target); end
    tick();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h120);
    tick();
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL first_misp got %0h exp 1", bif.mispredict); end
    checks++; if (bif.redirect_pc !== 32'h120) begin errors++; $display("FAIL first_redirect got %0h exp 120", bif.redirect_pc); end
    checks++; if (bif.mispredict_count !== 16'd1) begin errors++; $display("FAIL first_count got %0h exp 1", bif.mispredict_count); end
    drive(0, 0, 32'h100, 32'h20, 0, 0, 32'h0);
    checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL first_ctr2_pred got %0h exp 1", bif.pred_taken); end
    checks++; if (bif.f_ready !== 1'b0) begin errors++; $display("FAIL first_pulse_ready got %0h exp 0", bif.f_ready); end
    tick();
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL first_pulse_len got %0h exp 0", bif.mispredict); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 32'h100, 32'h20, 0, 0, 32'h0);
      checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_pred%0d got %0h exp 1", k, bif.pred_taken); end
      tick();
      drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h120);
      tick();
      checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL sat_nomisp%0d got %0h exp 0", k, bif.mispredict); end
    end
    drive(1, 1, 32'h100, 32'h20, 0, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h120);
    tick();
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL sat_nt_misp got %0h exp 1", bif.mispredict); end
    checks++; if (bif.redirect_pc !== 32'h104) begin errors++; $display("FAIL sat_nt_redirect got %0h exp 104", bif.redirect_pc); end
    checks++; if (bif.mispredict_count !== 16'(m_cnt)) begin errors++; $display("FAIL sat_count got %0h exp %0h", bif.mispredict_count, m_cnt); end
    idle();
    drive(0, 0, 32'h100, 32'h20, 0, 0, 32'h0);
    checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_held3 got %0h exp 1", bif.pred_taken); end
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < ND; i++) begin
      drive(1, 1, 32'h300 + 32'(4*i), 32'h40, 0, 0, 32'h0);
      checks++; if (bif.f_ready !== 1'b1) begin errors++; $display("FAIL full_fill%0d_ready got %0h exp 1", i, bif.f_ready); end
      tick();
    end
    drive(1, 1, 32'h310, 32'h40, 0, 0, 32'h0);
    checks++; if (bif.f_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0h exp 0", bif.f_ready); end
    tick();
    drive(1, 1, 32'h314, 32'h40, 1, m_q[0].pred, 32'h340);
    checks++; if (bif.f_ready !== 1'b1) begin errors++; $display("FAIL full_poppush_ready got %0h exp 1", bif.f_ready); end
    tick();
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL full_poppush_misp got %0h exp 0", bif.mispredict); end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checks++; if (bif.f_ready !== 1'b0) begin errors++; $display("FAIL full_still4 got %0h exp 0", bif.f_ready); end
    for (int i = 0; i < ND; i++) begin
      drive(0, 0, 32'h0, 32'h0, 1, m_q[0].pred, m_q[0].pc + 32'h40);
      tick();
      checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL full_drain%0d_misp got %0h exp 0", i, bif.mispredict); end
    end
    checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL full_drain_err got %0h exp 0", bif.err); end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checks++; if (bif.f_ready !== 1'b1) begin errors++; $display("FAIL full_empty_ready got %0h exp 1", bif.f_ready); end
  endtask

  task automatic test_flush_redirect();
    idle();
    for (int k = 0; k < 4 && !m_pred(32'h200); k++) begin
      drive(1, 1, 32'h200, 32'h10, 0, 0, 32'h0); tick();
      drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h210); tick();
      idle();
    end
    drive(1, 1, 32'h200, 32'h10, 0, 0, 32'h0);
    checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL flush_pred got %0h exp 1", bif.pred_taken); end
    tick();
    drive(1, 1, 32'h204, 32'h10, 0, 0, 32'h0); tick();
    drive(1, 1, 32'h208, 32'h10, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    tick();
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL flush_misp got %0h exp 1", bif.mispredict); end
    checks++; if (bif.redirect_pc !== 32'h204) begin errors++; $display("FAIL flush_redirect got %0h exp 204", bif.redirect_pc); end
    checks++; if (bif.mispredict_count !== 16'(m_cnt)) begin errors++; $display("FAIL flush_count got %0h exp %0h", bif.mispredict_count, m_cnt); end
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    tick();
    checks++; if (bif.err !== 1'b1) begin errors++; $display("FAIL flush_err got %0h exp 1", bif.err); end
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL flush_emptypop_misp got %0h exp 0", bif.mispredict); end
    idle();
    checks++; if (bif.err !== 1'b1) begin errors++; $display("FAIL flush_err_sticky got %0h exp 1", bif.err); end
  endtask

  task automatic test_misp_push();
    bit p;
    idle();
    p = m_pred(32'h400);
    drive(1, 1, 32'h400, 32'h80, 0, 0, 32'h0); tick();
    drive(1, 1, 32'h404, 32'h8, 1, !p, 32'h480);
    tick();
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL mp_misp got %0h exp 1", bif.mispredict); end
    checks++; if (bif.redirect_pc !== m_redir) begin errors++; $display("FAIL mp_redirect got %0h exp %0h", bif.redirect_pc, m_redir); end
    idle();
    for (int i = 0; i < ND; i++) begin
      drive(1, 1, 32'h600 + 32'(4*i), 32'h4, 0, 0, 32'h0);
      checks++; if (bif.f_ready !== 1'b1) begin errors++; $display("FAIL mp_refill%0d_ready got %0h exp 1", i, bif.f_ready); end
      tick();
    end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checks++; if (bif.f_ready !== 1'b0) begin errors++; $display("FAIL mp_refill_full got %0h exp 0", bif.f_ready); end
    for (int i = 0; i < ND; i++) begin
      drive(0, 0, 32'h0, 32'h0, 1, m_q[0].pred, 32'h0);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bit p;
    idle();
    p = m_pred(32'h500);
    drive(1, 1, 32'h500, 32'h0, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, !p, 32'h900);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL rmid_misp got %0h exp 0", bif.mispredict); end
    checks++; if (bif.mispredict_count !== 16'h0) begin errors++; $display("FAIL rmid_count got %0h exp 0", bif.mispredict_count); end
    checks++; if (bif.err !== 1'b0) begin errors++; $display("FAIL rmid_err got %0h exp 0", bif.err); end
    checks++; if (bif.redirect_pc !== 32'h0) begin errors++; $display("FAIL rmid_redirect got %0h exp 0", bif.redirect_pc); end
    @(negedge clk);
    bif.r_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NB; i++) begin
      drive(0, 0, 32'(4*i), 32'h0, 0, 0, 32'h0);
      checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL rmid_ctr%0d got %0h exp 0", i, bif.pred_taken); end
    end
    drive(1, 1, 32'h0, 32'h8, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h8); tick();
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL rmid_wnt_misp got %0h exp 1", bif.mispredict); end
    idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL rmid_wnt_to_wt got %0h exp 1", bif.pred_taken); end
  endtask

  task automatic test_random();
    bit          fv, fb, rv, rb;
    logic [31:0] pc, imm, rt;
    for (int n = 0; n < 400; n++) begin
      fv  = ($urandom % 100) < 70;
      fb  = ($urandom % 100) < 80;
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = $urandom;
      rv  = (m_q.size() > 0) ? (($urandom % 100) < 45) : (($urandom % 100) < 3);
      rb  = $urandom % 2;
      rt  = $urandom & 32'hFFFF_FFFC;
      drive(fv, fb, pc, imm, rv, rb, rt);
      checks++; if (bif.pred_taken !== m_pred(pc)) begin errors++; $display("FAIL rnd%0d_pred got %0h exp %0h", n, bif.pred_taken, m_pred(pc)); end
      checks++; if (bif.pred_target !== pc + imm) begin errors++; $display("FAIL rnd%0d_target got %0h exp %0h", n, bif.pred_target, pc + imm); end
      checks++; if (bif.f_ready !== m_ready()) begin errors++; $display("FAIL rnd%0d_ready got %0h exp %0h", n, bif.f_ready, m_ready()); end
      tick();
      checks++; if (bif.mispredict !== m_misp) begin errors++; $display("FAIL rnd%0d_misp got %0h exp %0h", n, bif.mispredict, m_misp); end
      checks++; if (bif.mispredict_count !== 16'(m_cnt)) begin errors++; $display("FAIL rnd%0d_count got %0h exp %0h", n, bif.mispredict_count, m_cnt); end
      checks++; if (bif.err !== m_err) begin errors++; $display("FAIL rnd%0d_err got %0h exp %0h", n, bif.err, m_err); end
      if (m_misp) begin
        checks++; if (bif.redirect_pc !== m_redir) begin errors++; $display("FAIL rnd%0d_redirect got %0h exp %0h", n, bif.redirect_pc, m_redir); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_mispredict();
    test_saturation();
    test_full();
    test_flush_redirect();
    test_misp_push();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
